// File: rtl/vcpu32_pkg.sv
// Shared vcpu32 definitions: word width, register-file port limits and the scan FSM state encoding.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

package vcpu32_pkg;

    localparam int WORD_W = `WORD_LENGTH;
    localparam int WORD_MSB = WORD_W - 1;

    localparam int MIN_RD_PORTS = 1;
    localparam int MAX_RD_PORTS = 4;
    localparam int MIN_WR_PORTS = 1;
    localparam int MAX_WR_PORTS = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE,
        DONE
    } scan_state_t;

endpackage

// File: rtl/register_file_scan_if.sv
// Bus bundle for register_file_scan: packed read/write ports plus the serial scan port.
interface register_file_scan_if #(
    parameter int AW     = 4,
    parameter int WIDTH  = vcpu32_pkg::WORD_W,
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*AW-1:0]    rdAddr;
    logic [NUM_RD*WIDTH-1:0] rdData;
    logic [NUM_WR-1:0]       wrEn;
    logic [NUM_WR*AW-1:0]    wrAddr;
    logic [NUM_WR*WIDTH-1:0] wrData;
    logic                    scanStart;
    logic                    scanWrite;
    logic                    sEnable;
    logic                    sIn;
    logic                    sOut;
    logic                    scanBusy;
    logic                    scanDone;
    vcpu32_pkg::scan_state_t scanState;

    // Scan handshake: scanStart is a one-cycle request accepted only while scanBusy=0;
    // once accepted, scanBusy stays high until the cycle after the one-cycle scanDone
    // pulse, and each sEnable=1 cycle in SHIFT consumes sIn and advances sOut by one bit.
    modport master (
        output rdAddr, wrEn, wrAddr, wrData, scanStart, scanWrite, sEnable, sIn,
        input  rdData, sOut, scanBusy, scanDone, scanState
    );

    modport slave (
        input  rdAddr, wrEn, wrAddr, wrData, scanStart, scanWrite, sEnable, sIn,
        output rdData, sOut, scanBusy, scanDone, scanState
    );
endinterface

// File: rtl/regfile_scan_ctrl.sv
// Serial scan engine: walks every register, shifts it out LSB first and optionally writes back sIn data.
module regfile_scan_ctrl
    import vcpu32_pkg::*;
#(
    parameter int  SIZE  = 16,
    parameter int  WIDTH = WORD_W,
    localparam int AW    = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scanStart,
    input  logic              scanWrite,
    input  logic              sEnable,
    input  logic              sIn,
    input  logic [WIDTH-1:0]  rdData,
    output logic [AW-1:0]     scanAdr,
    output logic              wrEn,
    output logic [WIDTH-1:0]  wrData,
    output logic              sOut,
    output logic              scanBusy,
    output logic              scanDone,
    output scan_state_t       state
);
    localparam int CW = $clog2(WIDTH) + 1;

    scan_state_t     state_q, state_d;
    logic [WIDTH-1:0] sh_reg;
    logic [CW-1:0]    shift_cnt;
    logic             wr_latched;
    logic             last_bit;
    logic             last_adr;

    assign last_bit = (shift_cnt == CW'(WIDTH - 1));
    assign last_adr = (scanAdr == AW'(SIZE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        scanBusy = (state_q != IDLE);
        scanDone = 1'b0;
        sOut     = 1'b0;
        wrEn     = 1'b0;
        case (state_q)
            IDLE:  if (scanStart) state_d = LOAD;
            LOAD:  state_d = SHIFT;
            SHIFT: begin
                sOut = sh_reg[0];
                if (sEnable && last_bit) state_d = STORE;
            end
            // r0 is hard-wired zero, so scan write-back skips it
            STORE: begin
                wrEn    = wr_latched && (scanAdr != '0);
                state_d = last_adr ? DONE : LOAD;
            end
            DONE: begin
                scanDone = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_reg     <= '0;
            shift_cnt  <= '0;
            scanAdr    <= '0;
            wr_latched <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (scanStart) begin
                    scanAdr    <= '0;
                    wr_latched <= scanWrite;
                end
                LOAD: begin
                    sh_reg    <= rdData;
                    shift_cnt <= '0;
                end
                SHIFT: if (sEnable) begin
                    sh_reg    <= {sIn, sh_reg[WIDTH-1:1]};
                    shift_cnt <= shift_cnt + 1'b1;
                end
                STORE: if (!last_adr) scanAdr <= scanAdr + 1'b1;
                default: ;
            endcase
        end
    end

    assign wrData = sh_reg;
    assign state  = state_q;

endmodule

// File: rtl/register_file_scan.sv
// Multi-port register file with zero r0, write-to-read bypass and a serial scan chain over all registers.
module register_file_scan
    import vcpu32_pkg::*;
#(
    parameter int SIZE   = 16,
    parameter int WIDTH  = WORD_W,
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic clk,
    input  logic rst,
    register_file_scan_if.slave bus
);
    localparam int AW = $clog2(SIZE);

    logic [WIDTH-1:0]        regs    [SIZE];
    logic [AW-1:0]           ra      [NUM_RD];
    logic [WIDTH-1:0]        rd_word [NUM_RD];
    logic [AW-1:0]           wa      [NUM_WR];
    logic [WIDTH-1:0]        wd      [NUM_WR];
    logic [NUM_WR-1:0]       fwe;
    logic [NUM_RD*WIDTH-1:0] rd_flat;

    logic             scan_busy;
    logic             scan_we;
    logic [AW-1:0]    scan_adr;
    logic [WIDTH-1:0] scan_wdata;
    logic [WIDTH-1:0] scan_rdata;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign ra[k] = bus.rdAddr[k*AW +: AW];
    end

    // Functional writes stall while the scan engine owns the file
    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign wa[j]  = bus.wrAddr[j*AW +: AW];
        assign wd[j]  = bus.wrData[j*WIDTH +: WIDTH];
        assign fwe[j] = bus.wrEn[j] && !scan_busy && (wa[j] != '0);
    end

    // Ports are applied highest-first so port 0 lands last and wins a conflict
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SIZE; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < SIZE; i++) begin
                for (int j = NUM_WR - 1; j >= 0; j--) begin
                    if (fwe[j] && (wa[j] == AW'(i))) regs[i] <= wd[j];
                end
            end
            if (scan_we) regs[scan_adr] <= scan_wdata;
        end
    end

    always_comb begin
        rd_flat = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_word[k] = (ra[k] == '0) ? '0 : regs[ra[k]];
            if (BYPASS != 0) begin
                for (int j = NUM_WR - 1; j >= 0; j--) begin
                    if (fwe[j] && (wa[j] == ra[k])) rd_word[k] = wd[j];
                end
            end
            rd_flat[k*WIDTH +: WIDTH] = rd_word[k];
        end
    end

    assign bus.rdData   = rd_flat;
    assign bus.scanBusy = scan_busy;
    assign scan_rdata   = regs[scan_adr];

    regfile_scan_ctrl #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_scan_ctrl (
        .clk       (clk),
        .rst       (rst),
        .scanStart (bus.scanStart),
        .scanWrite (bus.scanWrite),
        .sEnable   (bus.sEnable),
        .sIn       (bus.sIn),
        .rdData    (scan_rdata),
        .scanAdr   (scan_adr),
        .wrEn      (scan_we),
        .wrData    (scan_wdata),
        .sOut      (bus.sOut),
        .scanBusy  (scan_busy),
        .scanDone  (bus.scanDone),
        .state     (bus.scanState)
    );

endmodule

// File: doc/register_file_scan.md
REGISTER_FILE_SCAN -- requirements
Module: register_file_scan

Interface
REQ-001 SIZE, 16, number of registers; power of two, >= 2; AW = $clog2(SIZE).
REQ-002 WIDTH, `WORD_LENGTH, register width in bits; >= 2.
REQ-003 NUM_RD, 3, number of asynchronous read ports (1..4).
REQ-004 NUM_WR, 2, number of synchronous write ports (1..2).
REQ-005 BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = none.
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 rdAddr  in  NUM_RD*AW  packed read addresses; port k at bits [k*AW +: AW].
REQ-009 rdData  out  NUM_RD*WIDTH  packed read data; port k at bits [k*WIDTH +: WIDTH].
REQ-010 wrEn  in  NUM_WR  per-port write enable.
REQ-011 wrAddr  in  NUM_WR*AW  packed write addresses.
REQ-012 wrData  in  NUM_WR*WIDTH  packed write data.
REQ-013 scanStart  in  1  one-cycle pulse; starts a full-file scan.
REQ-014 scanWrite  in  1  sampled with scanStart; 1 = shift-in data replaces register contents.
REQ-015 sEnable  in  1  shift qualifier; the scan advances only in cycles where it is high.
REQ-016 sIn  in  1  serial scan input.
REQ-017 sOut  out  1  serial scan output.
REQ-018 scanBusy  out  1  high while the scan FSM is not IDLE.
REQ-019 scanDone  out  1  one-cycle pulse when a scan completes.

Function
REQ-020 Register 0 SHALL read as zero on every port; all writes to it (functional or scan) SHALL be discarded.
REQ-021 Reads SHALL be combinational: rdData[k] = reg[rdAddr[k]], with zero latency.
REQ-022 Writes SHALL take effect at the rising clk edge when wrEn[j]=1 and wrAddr[j]!=0.
REQ-023 When both write ports target the same address, port 0 SHALL win and port 1's write SHALL be dropped.
REQ-024 When BYPASS=1 and a read address equals an enabled, non-zero write address in the same cycle, rdData SHALL return that wrData, with port 0 taking priority; when BYPASS=0 it SHALL return the old value.
REQ-025 The scan FSM states SHALL be IDLE, LOAD, SHIFT, STORE and DONE.
REQ-026 IDLE -> LOAD on scanStart; the FSM SHALL clear scanAdr to 0 and latch scanWrite; scanStart outside IDLE SHALL be ignored.
REQ-027 LOAD: the FSM SHALL copy reg[scanAdr] into a WIDTH-bit shift register, clear shiftCnt, and move to SHIFT after one cycle.
REQ-028 SHIFT: sOut SHALL continuously present shReg[0] (LSB first); each sEnable=1 cycle SHALL perform shReg <= {sIn, shReg[WIDTH-1:1]} and shiftCnt+1; after the WIDTH-th shift the FSM SHALL move to STORE.
REQ-029 With sEnable=0 the FSM SHALL hold all state, including sOut.
REQ-030 STORE: if the latched scanWrite=1 and scanAdr!=0, the FSM SHALL write shReg to reg[scanAdr]; if scanAdr==SIZE-1 it SHALL go to DONE, otherwise scanAdr+1 and go to LOAD.
REQ-031 DONE SHALL assert scanDone for one cycle and then return to IDLE.
REQ-032 While scanBusy=1, functional writes SHALL be ignored (the core stalls on scanBusy); reads SHALL remain functional.
REQ-033 In IDLE, sOut SHALL be 0.
REQ-034 A full scan SHALL take SIZE*(WIDTH+2)+2 cycles with sEnable held high, measured from the scanStart edge through the scanDone cycle.

Reset
REQ-035 Assertion of rst SHALL asynchronously clear all registers, shReg, shiftCnt and scanAdr, force the FSM to IDLE, and drive sOut, scanBusy and scanDone to 0; this applies mid-scan as well.
REQ-036 After rst deassertion, rdData SHALL read 0 on all ports.

Structure
REQ-037 The scan FSM state enum, the `WORD_LENGTH-derived width constants and the port-count limits SHALL reside in the shared package vcpu32_pkg.
REQ-038 The serial engine (FSM, shReg, shiftCnt, scanAdr) SHALL be the single sub-module regfile_scan_ctrl; storage, ports and bypass stay in the top module.

Verification
REQ-039 Write 0xDEADBEEF to r5 via port 0, then read r5 on all ports -> 0xDEADBEEF; write r0 -> r0 still reads 0.
REQ-040 Same cycle: port0 writes r3=0x11 and port1 writes r3=0x22 -> r3=0x11 next cycle; with BYPASS=1, rdAddr=3 in that cycle reads 0x11.
REQ-041 Preload r1=0x00000001 and rN=N, scanStart with scanWrite=0 and sEnable=1 -> sOut emits every register LSB-first in address order; registers unchanged; scanDone after SIZE*(WIDTH+2)+2 cycles.
REQ-042 scanWrite=1 with sIn driving the pattern 0xA5A5A5A5 for each word -> every register except r0 reads 0xA5A5A5A5 afterwards; a functional wrEn asserted mid-scan has no effect.
REQ-043 Toggle sEnable 50% during SHIFT -> same sOut bit sequence as REQ-041, with the scan duration extended accordingly.
REQ-044 Assert rst mid-SHIFT -> scanBusy=0, sOut=0, all registers read 0; a new scanStart then runs a complete scan.
